fft_stage_shell: RTL

//  Engine-agnostic, parametrised accelerator shell for one FFT butterfly stage inside the cohort acc_unit.

---
 rtl/acc_pkg.sv | 8 +
 rtl/fft_shell_pkg.sv | 11 +
 rtl/decoupled_vr_if.sv | 8 +
 rtl/fft_frame_buffer.sv | 24 ++
 rtl/fft_stage_shell.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared accelerator-unit configuration types
package acc_pkg;
   typedef struct packed {
      logic [31:0] base_addr;
      logic [15:0] len;
      logic [15:0] flags;
   } acc_config_t;
endpackage

// File: rtl/fft_shell_pkg.sv
// fft_shell_pkg: FSM states, packing modes and bypass bit positions for the FFT stage shell
package fft_shell_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CONSUME, S_ISSUE, S_WAIT, S_PRODUCE} state_t;
   typedef enum logic {PACK_SPLIT, PACK_PACKED} pack_mode_e;
   localparam int BYP_IN  = 1;
   localparam int BYP_OUT = 0;
   localparam int BEAT_W  = 64;
   function automatic int frame_beats(input int n, input int pm);
      return (pm != 0) ? n : 2 * n;
   endfunction
endpackage

// File: rtl/decoupled_vr_if.sv
// decoupled_vr_if: valid/ready stream with a data word
interface decoupled_vr_if #(parameter int W = 64);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: frame storage with a single-beat write port and a full-frame parallel load
module fft_frame_buffer #(
   parameter int DEPTH = 128,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic                     load,
   input  logic [DEPTH*W-1:0]       ldata,
   output logic [DEPTH*W-1:0]       q
);
   logic [DEPTH*W-1:0] mem_q, mem_d;
   // a full-frame load takes priority over a single beat write
   always_comb begin
      mem_d = mem_q;
      if (load) mem_d = ldata;
      else if (we) mem_d[waddr*W +: W] = wdata;
   end
   // storage is intentionally left unreset
   always_ff @(posedge clk) mem_q <= mem_d;
   assign q = mem_q;
endmodule

// File: rtl/fft_stage_shell.sv
// fft_stage_shell: gathers a complex frame, runs it through an external stage engine and drains the result
// Optional perf counters are enabled with FFT_SHELL_PERF_CNT_EN.
module fft_stage_shell
   import fft_shell_pkg::*;
#(
   parameter int N_POINTS    = 64,
   parameter int SAMPLE_W    = 32,
   parameter int PACK_MODE   = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  acc_pkg::acc_config_t         acc_config,
   input  logic [2:0]                   bypass_control,
   decoupled_vr_if.slave                consumer_data,
   decoupled_vr_if.master               producer_data,
   input  logic                         fwd_in_valid,
   output logic                         fwd_in_ready,
   input  logic [2*N_POINTS*64-1:0]     fwd_in_data,
   output logic                         fwd_out_valid,
   input  logic                         fwd_out_ready,
   output logic [2*N_POINTS*64-1:0]     fwd_out_data,
   output logic                         eng_in_valid,
   input  logic                         eng_in_ready,
   output logic [N_POINTS*SAMPLE_W-1:0] eng_in_real,
   output logic [N_POINTS*SAMPLE_W-1:0] eng_in_imag,
   input  logic                         eng_out_valid,
   output logic                         eng_out_ready,
   input  logic [N_POINTS*SAMPLE_W-1:0] eng_out_real,
   input  logic [N_POINTS*SAMPLE_W-1:0] eng_out_imag,
   output logic                         err_timeout,
   output logic [31:0]                  perf_frames,
   output logic [31:0]                  perf_busy_cyc
);
   localparam int            DEPTH  = 2 * N_POINTS;
   localparam int            BEATS  = frame_beats(N_POINTS, PACK_MODE);
   localparam int            CW     = $clog2(DEPTH);
   localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
   localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT_CYC - 1);
   localparam bit            PACKED = PACK_MODE == int'(PACK_PACKED);

   state_t                 state_q, state_d;
   logic [1:0]             byp_q, byp_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   err_q, err_d;
   logic                   ibuf_we, ibuf_ld, obuf_load, done, src_packed;
   logic [DEPTH*64-1:0]    ibuf_q, obuf_q, obuf_ld;
   logic [63:0]            beat;
   logic                   unused;

   fft_frame_buffer #(.DEPTH(DEPTH), .W(64)) u_ibuf (
      .clk(clk), .we(ibuf_we), .waddr(cnt_q), .wdata(consumer_data.data),
      .load(ibuf_ld), .ldata(fwd_in_data), .q(ibuf_q)
   );

   fft_frame_buffer #(.DEPTH(DEPTH), .W(64)) u_obuf (
      .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
      .load(obuf_load), .ldata(obuf_ld), .q(obuf_q)
   );

   // stream frames in packed mode keep imag in the upper word of beat k; everything else is split layout
   assign src_packed = PACKED && byp_q[BYP_IN];

   // engine view of the input buffer and split-layout image of the engine result
   always_comb begin
      eng_in_real = '0;
      eng_in_imag = '0;
      obuf_ld     = '0;
      for (int k = 0; k < N_POINTS; k++) begin
         eng_in_real[k*SAMPLE_W +: SAMPLE_W]  = ibuf_q[k*64 +: SAMPLE_W];
         eng_in_imag[k*SAMPLE_W +: SAMPLE_W]  = src_packed ? ibuf_q[k*64+32 +: SAMPLE_W] : ibuf_q[(N_POINTS+k)*64 +: SAMPLE_W];
         obuf_ld[k*64 +: 64]                  = 64'(eng_out_real[k*SAMPLE_W +: SAMPLE_W]);
         obuf_ld[(N_POINTS+k)*64 +: 64]       = 64'(eng_out_imag[k*SAMPLE_W +: SAMPLE_W]);
      end
   end

   assign beat = PACKED ? {obuf_q[(N_POINTS+cnt_q)*64 +: 32], obuf_q[cnt_q*64 +: 32]} : obuf_q[cnt_q*64 +: 64];

   // frame sequencing: gather, issue, wait for the engine, drain
   always_comb begin
      state_d   = state_q;
      byp_d     = byp_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      ibuf_we   = 1'b0;
      ibuf_ld   = 1'b0;
      obuf_load = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            byp_d = bypass_control[1:0];
            cnt_d = '0;
            if (byp_d[BYP_IN] ? consumer_data.valid : fwd_in_valid) state_d = S_CONSUME;
         end
         S_CONSUME: begin
            if (!byp_q[BYP_IN]) begin
               ibuf_ld = 1'b1;
               state_d = S_ISSUE;
            end else if (consumer_data.valid) begin
               ibuf_we = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (eng_in_ready) begin
               tmo_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (eng_out_valid) begin
               obuf_load = 1'b1;
               cnt_d     = '0;
               state_d   = S_PRODUCE;
            end else if (tmo_q == TLAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PRODUCE: begin
            if (byp_q[BYP_OUT] ? producer_data.ready : fwd_out_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (!byp_q[BYP_OUT] || cnt_q == LAST) begin
                  cnt_d   = '0;
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // control state registers; a reset mid-frame simply drops the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         byp_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         byp_q   <= byp_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign consumer_data.ready = state_q == S_CONSUME && byp_q[BYP_IN];
   assign fwd_in_ready        = state_q == S_CONSUME && !byp_q[BYP_IN];
   assign eng_in_valid        = state_q == S_ISSUE;
   assign eng_out_ready       = state_q == S_WAIT;
   assign producer_data.valid = state_q == S_PRODUCE && byp_q[BYP_OUT];
   assign producer_data.data  = producer_data.valid ? beat : '0;
   assign fwd_out_valid       = state_q == S_PRODUCE && !byp_q[BYP_OUT];
   assign fwd_out_data        = obuf_q;
   assign err_timeout         = err_q;

`ifdef FFT_SHELL_PERF_CNT_EN
   logic [31:0] frames_q, frames_d, busy_q, busy_d;
   // saturating completed-frame and busy-cycle counters
   always_comb begin
      frames_d = frames_q + 32'(done && frames_q != '1);
      busy_d   = busy_q + 32'(state_q != S_IDLE && busy_q != '1);
   end
   // perf counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_q <= '0;
         busy_q   <= '0;
      end else begin
         frames_q <= frames_d;
         busy_q   <= busy_d;
      end
   end
   assign perf_frames   = frames_q;
   assign perf_busy_cyc = busy_q;
`else
   assign perf_frames   = '0;
   assign perf_busy_cyc = '0;
`endif

   assign unused = ^{acc_config, bypass_control[2], ibuf_q, done};
endmodule
